// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//   Iterative multiply/divide unit that owns the CPU's HI/LO register pair.
//   A multiply runs 32 shift-add steps and a divide runs 32 restoring steps,
//   both on operand magnitudes. A final FIX cycle applies sign correction
//   and writes HI/LO. While the unit is busy, it stalls the pipeline if any
//   instruction tries to touch HI/LO.
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   sig_start, sig_op  start request and operation code
//                      (00 multu, 01 mult, 10 divu, 11 div)
//   src_a, src_b       multiplicand/dividend and multiplier/divisor
//   sig_mf_req         mfhi/mflo pending in the Decode stage
//   sig_mthi, sig_mtlo direct write of write_data into HI/LO (only when idle)
//   hi, lo             HI/LO register outputs
//   busy, done         sequence in progress; one-cycle result pulse
//   stall              combinational stall request to the hazard unit
module mult_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_start,
  input  logic [1:0]       sig_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             sig_mf_req,
  input  logic             sig_mthi,
  input  logic             sig_mtlo,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;   // product / quotient must be negated
  logic               neg_rem;   // remainder takes the dividend's sign
  logic               div_zero;
  logic [WIDTH-1:0]   operand;   // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0]   a_raw;     // unmodified dividend for divide-by-zero result
  // mult: {product upper, multiplier/product lower}; div: {remainder, quotient}
  logic [2*WIDTH-1:0] acc;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sig_start) state_nxt = S_RUN;
      S_RUN:   if (count == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy & (sig_start | sig_mf_req | sig_mthi | sig_mtlo);

  always_comb begin
    op_signed = sig_op[0];
    a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply step: add the multiplicand to the upper half, keep the carry,
    // then shift the whole product right by one.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Restoring-divide step on the {rem, quot} pair shifted left by one.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, operand};
    acc_step = '0;
    if (is_div) begin
      if (rem_sh >= {1'b0, operand})
        acc_step = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      operand  <= '0;
      a_raw    <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sig_start) begin
            is_div   <= sig_op[1];
            neg_res  <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem  <= op_signed & src_a[WIDTH-1];
            div_zero <= (src_b == '0);
            a_raw    <= src_a;
            operand  <= sig_op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (sig_op[1] ? a_mag : b_mag)};
            count    <= '0;
          end else begin
            if (sig_mthi) hi <= write_data;
            if (sig_mtlo) lo <= write_data;
          end
        end
        S_RUN: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div) begin
            if (div_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
